// File: rtl/sobel_gradient_stage_pkg.sv
// Shared types, default geometry, Sobel kernels and gradient helpers
// for the edge-detection pipeline.
package sobel_gradient_stage_pkg;

    localparam int IMAGE_WIDTH  = 512;
    localparam int IMAGE_HEIGHT = 512;

    typedef logic [7:0]         pixel_t;
    typedef logic signed [10:0] grad_t;

    // 3x3 neighbourhood, element 0 = top-left, row-major.
    typedef logic [8:0][7:0] window_t;

    typedef enum logic [1:0] {
        DIR_0   = 2'd0,
        DIR_45  = 2'd1,
        DIR_90  = 2'd2,
        DIR_135 = 2'd3
    } dir_t;

    // Sobel kernels, row-major, index 0 = top-left.
    localparam int sobel_x [9] = '{-1, 0, 1, -2, 0, 2, -1, 0, 1};
    localparam int sobel_y [9] = '{-1, -2, -1, 0, 0, 0, 1, 2, 1};

    // |g| for g in [-1020, 1020] always fits in 10 bits.
    function automatic logic [9:0] abs_grad(input grad_t g);
        return 10'(g[10] ? -g : g);
    endfunction

    // Quantize gradient direction into four 45-degree bins using the
    // 2/5 and 5/2 slope thresholds (tan 22.5 / tan 67.5 approximations).
    function automatic dir_t quantize_dir(input grad_t gx, input grad_t gy);
        logic [9:0]  ax;
        logic [9:0]  ay;
        logic [12:0] ax2;
        logic [12:0] ax5;
        logic [12:0] ay2;
        logic [12:0] ay5;
        ax  = abs_grad(gx);
        ay  = abs_grad(gy);
        ax2 = 13'(ax) * 13'd2;
        ax5 = 13'(ax) * 13'd5;
        ay2 = 13'(ay) * 13'd2;
        ay5 = 13'(ay) * 13'd5;
        if (gx == '0 && gy == '0) begin
            return DIR_0;
        end else if (ay5 < ax2) begin
            return DIR_0;
        end else if (ay2 > ax5) begin
            return DIR_90;
        end else if (gx[10] == gy[10]) begin
            return DIR_45;
        end else begin
            return DIR_135;
        end
    endfunction

endpackage

// File: rtl/sobel_gradient_stage_line_window.sv
// line_window_3x3: raster position counters, two line buffers and a 3x3
// shift window. Presents a registered window one cycle after the pixel
// that completes it, together with a valid strobe and a last-window flag.
module line_window_3x3 #(
    parameter int IMAGE_WIDTH  = sobel_gradient_stage_pkg::IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = sobel_gradient_stage_pkg::IMAGE_HEIGHT
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              in_valid_i,
    input  logic                              in_sof_i,
    input  logic [7:0]                        in_pixel_i,
    output sobel_gradient_stage_pkg::window_t win_o,
    output logic                              win_valid_o,
    output logic                              win_last_o
);
    import sobel_gradient_stage_pkg::*;

    localparam int CW = $clog2(IMAGE_WIDTH);
    localparam int RW = $clog2(IMAGE_HEIGHT);
    localparam logic [CW-1:0] LAST_COL = CW'(IMAGE_WIDTH - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(IMAGE_HEIGHT - 1);

    logic [CW-1:0] col_q, col_d, cur_col;
    logic [RW-1:0] row_q, row_d, cur_row;
    logic          valid_q, valid_d;
    logic          last_q, last_d;

    // line1 holds row r-1, line2 holds row r-2; never reset, stale data is
    // masked because a window needs two freshly written rows above it.
    pixel_t  line1_q [IMAGE_WIDTH];
    pixel_t  line2_q [IMAGE_WIDTH];
    window_t win_q, win_d;

    // Position of the current pixel, next counters, next window and tags.
    always_comb begin
        cur_col = in_sof_i ? '0 : col_q;
        cur_row = in_sof_i ? '0 : row_q;
        col_d   = col_q;
        row_d   = row_q;
        valid_d = 1'b0;
        last_d  = 1'b0;
        win_d   = win_q;
        if (in_valid_i) begin
            if (cur_col == LAST_COL) begin
                col_d = '0;
                row_d = (cur_row == LAST_ROW) ? '0 : cur_row + 1'b1;
            end else begin
                col_d = cur_col + 1'b1;
                row_d = cur_row;
            end
            valid_d = (cur_row >= RW'(2)) && (cur_col >= CW'(2));
            last_d  = valid_d && (cur_row == LAST_ROW) && (cur_col == LAST_COL);
            win_d[0] = win_q[1];
            win_d[1] = win_q[2];
            win_d[2] = line2_q[cur_col];
            win_d[3] = win_q[4];
            win_d[4] = win_q[5];
            win_d[5] = line1_q[cur_col];
            win_d[6] = win_q[7];
            win_d[7] = win_q[8];
            win_d[8] = in_pixel_i;
        end
    end

    // Position counters and window tags; reset returns to (0,0).
    always_ff @(posedge clk) begin
        if (rst) begin
            col_q   <= '0;
            row_q   <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            col_q   <= col_d;
            row_q   <= row_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

    // Line buffers and shift window move only on accepted pixels.
    always_ff @(posedge clk) begin
        if (in_valid_i && !rst) begin
            line2_q[cur_col] <= line1_q[cur_col];
            line1_q[cur_col] <= in_pixel_i;
            win_q            <= win_d;
        end
    end

    assign win_o       = win_q;
    assign win_valid_o = valid_q;
    assign win_last_o  = last_q;

endmodule

// File: rtl/sobel_gradient_stage.sv
// sobel_gradient_stage: 3x3 windowing followed by a two-stage pipeline
// (Gx/Gy, then saturated magnitude and quantized direction).
module sobel_gradient_stage #(
    parameter int IMAGE_WIDTH  = sobel_gradient_stage_pkg::IMAGE_WIDTH,
    parameter int IMAGE_HEIGHT = sobel_gradient_stage_pkg::IMAGE_HEIGHT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       in_sof,
    input  logic [7:0] in_pixel,
    output logic       out_valid,
    output logic [7:0] out_mag,
    output logic [1:0] out_dir,
    output logic       out_eof
);
    import sobel_gradient_stage_pkg::*;

    window_t win;
    logic    win_valid;
    logic    win_last;

    line_window_3x3 #(
        .IMAGE_WIDTH (IMAGE_WIDTH),
        .IMAGE_HEIGHT(IMAGE_HEIGHT)
    ) u_window (
        .clk        (clk),
        .rst        (rst),
        .in_valid_i (in_valid),
        .in_sof_i   (in_sof),
        .in_pixel_i (in_pixel),
        .win_o      (win),
        .win_valid_o(win_valid),
        .win_last_o (win_last)
    );

    grad_t  gx_d, gy_d, gx_q, gy_q;
    logic   s1_valid_q, s1_eof_q;
    logic [9:0]  ax, ay;
    logic [10:0] mag_sum;
    pixel_t mag_d, mag_q;
    dir_t   dir_d, dir_q;
    logic   out_valid_q, out_eof_q;

    // Convolve the window with both kernels; result spans +/-1020.
    always_comb begin
        int acc_x;
        int acc_y;
        acc_x = 0;
        acc_y = 0;
        for (int i = 0; i < 9; i++) begin
            acc_x = acc_x + int'(win[i]) * sobel_x[i];
            acc_y = acc_y + int'(win[i]) * sobel_y[i];
        end
        gx_d = grad_t'(acc_x);
        gy_d = grad_t'(acc_y);
    end

    // Stage 1 valid/eof tags, dropped on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_eof_q   <= 1'b0;
        end else begin
            s1_valid_q <= win_valid;
            s1_eof_q   <= win_last;
        end
    end

    // Stage 1 gradient data; only meaningful when its tag is set.
    always_ff @(posedge clk) begin
        gx_q <= gx_d;
        gy_q <= gy_d;
    end

    // Saturated L1 magnitude and quantized direction.
    always_comb begin
        ax      = abs_grad(gx_q);
        ay      = abs_grad(gy_q);
        mag_sum = {1'b0, ax} + {1'b0, ay};
        mag_d   = (mag_sum > 11'd255) ? 8'd255 : mag_sum[7:0];
        dir_d   = quantize_dir(gx_q, gy_q);
    end

    // Stage 2 outputs; magnitude/direction hold between results.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_eof_q   <= 1'b0;
            mag_q       <= '0;
            dir_q       <= DIR_0;
        end else begin
            out_valid_q <= s1_valid_q;
            out_eof_q   <= s1_valid_q && s1_eof_q;
            if (s1_valid_q) begin
                mag_q <= mag_d;
                dir_q <= dir_d;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_eof   = out_eof_q;
    assign out_mag   = mag_q;
    assign out_dir   = dir_q;

endmodule

// File: tb/tb_sobel_gradient_stage.sv
// Bench for sobel_gradient_stage on a 6x6 image: directed edge/ramp frames,
// random frames with idle gaps, mid-frame reset and mid-frame restart.
module tb_sobel_gradient_stage;

  localparam int W = 6;
  localparam int H = 6;
  localparam int RESULTS = (W - 2) * (H - 2);

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_sof;
  logic [7:0] in_pixel;
  logic       out_valid;
  logic [7:0] out_mag;
  logic [1:0] out_dir;
  logic       out_eof;

  // clock / reset
  always #5 clk = ~clk;

  sobel_gradient_stage #(
    .IMAGE_WIDTH (W),
    .IMAGE_HEIGHT(H)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_sof   (in_sof),
    .in_pixel (in_pixel),
    .out_valid(out_valid),
    .out_mag  (out_mag),
    .out_dir  (out_dir),
    .out_eof  (out_eof)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // scoreboard: {due_cycle[31:0], eof, dir[1:0], mag[7:0]}
  logic [42:0] exp_q[$];
  int          img[H][W];
  int          mr = 0;
  int          mc = 0;
  int          res_cnt = 0;
  int          eof_cnt = 0;
  logic [7:0]  last_mag = '0;
  logic [1:0]  last_dir = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
    end
  endtask

  // reference: Sobel from the stored image, rules applied with plain integers
  function automatic int px(int r, int c);
    return img[r][c];
  endfunction

  task automatic model_accept(input int pix, input bit sof);
    int gx, gy, ax, ay, mag, dir;
    bit eof;
    if (sof) begin
      mr = 0;
      mc = 0;
    end
    img[mr][mc] = pix;
    if (mr >= 2 && mc >= 2) begin
      gx = (px(mr-2, mc) + 2*px(mr-1, mc) + px(mr, mc))
         - (px(mr-2, mc-2) + 2*px(mr-1, mc-2) + px(mr, mc-2));
      gy = (px(mr, mc-2) + 2*px(mr, mc-1) + px(mr, mc))
         - (px(mr-2, mc-2) + 2*px(mr-2, mc-1) + px(mr-2, mc));
      ax  = (gx < 0) ? -gx : gx;
      ay  = (gy < 0) ? -gy : gy;
      mag = (ax + ay > 255) ? 255 : ax + ay;
      if (gx == 0 && gy == 0)          dir = 0;
      else if (ay * 5 < ax * 2)        dir = 0;
      else if (ay * 2 > ax * 5)        dir = 2;
      else if ((gx < 0) == (gy < 0))   dir = 1;
      else                             dir = 3;
      eof = (mr == H - 1) && (mc == W - 1);
      exp_q.push_back({32'(cyc + 2), eof, 2'(dir), 8'(mag)});
    end
    if (mc == W - 1) begin
      mc = 0;
      mr = (mr == H - 1) ? 0 : mr + 1;
    end else begin
      mc = mc + 1;
    end
  endtask

  // one clock: advance, then compare outputs against the scoreboard
  task automatic tick();
    logic [42:0] e;
    @(posedge clk);
    #1;
    cyc++;
    if (out_valid === 1'b1) res_cnt++;
    if (out_eof === 1'b1) eof_cnt++;
    if (exp_q.size() > 0 && exp_q[0][42:11] == 32'(cyc)) begin
      e = exp_q.pop_front();
      check("out_valid", 32'(out_valid), 32'd1);
      check("out_mag", 32'(out_mag), 32'(e[7:0]));
      check("out_dir", 32'(out_dir), 32'(e[9:8]));
      check("out_eof", 32'(out_eof), 32'(e[10]));
      last_mag = e[7:0];
      last_dir = e[9:8];
    end else begin
      check("idle_valid", 32'(out_valid), 32'd0);
      check("idle_eof", 32'(out_eof), 32'd0);
      check("hold_mag", 32'(out_mag), 32'(last_mag));
      check("hold_dir", 32'(out_dir), 32'(last_dir));
    end
  endtask

  // driver tasks
  task automatic idle();
    in_valid = 1'b0;
    in_sof   = 1'($urandom_range(0, 1));
    in_pixel = 8'($urandom_range(0, 255));
    tick();
  endtask

  function automatic int pattern(int kind, int r, int c);
    case (kind)
      0:       return (c >= W / 2) ? 255 : 0;
      1:       return (r >= H / 2) ? 255 : 0;
      2:       return 10 * c;
      3:       return 10 * (r + c);
      4:       return 10 * (c - r) + 100;
      default: return int'($urandom_range(0, 255));
    endcase
  endfunction

  task automatic send_frame(input int kind, input int gap_pct, input bit with_sof, input int npix);
    int n;
    int pix;
    bit s;
    n = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        if (n < npix) begin
          while (int'($urandom_range(0, 99)) < gap_pct) idle();
          pix      = pattern(kind, r, c);
          s        = with_sof && (n == 0);
          in_valid = 1'b1;
          in_sof   = s;
          in_pixel = 8'(pix);
          tick();
          model_accept(pix, s);
          n++;
        end
      end
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic end_frame(input string tag, input int exp_res, input int exp_eof);
    repeat (4) idle();
    check({tag, "_results"}, 32'(res_cnt), 32'(exp_res));
    check({tag, "_eofs"}, 32'(eof_cnt), 32'(exp_eof));
    check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    res_cnt = 0;
    eof_cnt = 0;
  endtask

  task automatic apply_reset(input int cycles);
    rst = 1'b1;
    exp_q.delete();
    mr = 0;
    mc = 0;
    last_mag = '0;
    last_dir = '0;
    repeat (cycles) begin
      in_valid = 1'($urandom_range(0, 1));
      in_sof   = 1'($urandom_range(0, 1));
      in_pixel = 8'($urandom_range(0, 255));
      tick();
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    res_cnt  = 0;
    eof_cnt  = 0;
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    in_pixel = '0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        img[r][c] = 0;

    apply_reset(3);

    // directed frames, gap-free
    send_frame(0, 0, 1'b1, W * H);
    end_frame("vedge", RESULTS, 1);
    send_frame(1, 0, 1'b1, W * H);
    end_frame("hedge", RESULTS, 1);
    send_frame(2, 0, 1'b1, W * H);
    end_frame("ramp_col", RESULTS, 1);
    send_frame(3, 0, 1'b1, W * H);
    end_frame("ramp_diag", RESULTS, 1);
    send_frame(4, 0, 1'b1, W * H);
    end_frame("ramp_anti", RESULTS, 1);

    // random pixels with idle gaps; back-to-back ramp with gaps too
    for (int f = 0; f < 4; f++) begin
      send_frame(5, 30, 1'b1, W * H);
      end_frame("rand_gap", RESULTS, 1);
    end
    send_frame(3, 30, 1'b1, W * H);
    end_frame("diag_gap", RESULTS, 1);

    // reset mid-frame, then a frame without in_sof
    send_frame(5, 0, 1'b1, 20);
    apply_reset(3);
    send_frame(2, 0, 1'b0, W * H);
    end_frame("post_reset", RESULTS, 1);

    // mid-frame restart: partial frame (4 results, no eof) then a full frame
    send_frame(5, 20, 1'b1, 3 * W + 2);
    send_frame(5, 20, 1'b1, W * H);
    end_frame("restart", 4 + RESULTS, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
